// File: rtl/arbitro_compuerta_pkg.sv
// Shared types and defaults for the parking barrier arbiter: FSM states, lane ids
// and the per-state output pattern.
package arbitro_compuerta_pkg;

    localparam logic [7:0] PIN_CORRECTO_DEF = 8'b00001000;
    localparam int         MAX_INTENTOS_DEF = 3;
    localparam int         T_ESPERA_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        VERIF_PIN,
        ABIERTO_ENT,
        ABIERTO_SAL,
        ALARMA,
        BLOQUEO
    } estado_t;

    typedef enum logic {
        ENT = 1'b0,
        SAL = 1'b1
    } carril_t;

    typedef struct packed {
        logic cerrado;
        logic abierto;
        logic alarma;
        logic bloqueo;
        logic grant_ent;
        logic grant_sal;
    } salidas_t;

    // Moore output pattern for each state; abierto is only ever set with cerrado cleared.
    function automatic salidas_t salidas_de(estado_t e);
        salidas_t s;
        s = '0;
        s.cerrado = 1'b1;
        case (e)
            VERIF_PIN: s.grant_ent = 1'b1;
            ABIERTO_ENT: begin
                s.cerrado   = 1'b0;
                s.abierto   = 1'b1;
                s.grant_ent = 1'b1;
            end
            ABIERTO_SAL: begin
                s.cerrado   = 1'b0;
                s.abierto   = 1'b1;
                s.grant_sal = 1'b1;
            end
            ALARMA: begin
                s.alarma    = 1'b1;
                s.grant_ent = 1'b1;
            end
            BLOQUEO: s.bloqueo = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/arbitro_compuerta_if.sv
// Lane sensors / keypad towards the controller and barrier commands back out.
// master = lane side, slave = controller.
interface arbitro_compuerta_if;

    logic       VehiculoEnt;
    logic       VehiculoSal;
    logic       enterPin;
    logic [7:0] Pin;
    logic       TerminoEnt;
    logic       TerminoSal;

    logic       Cerrado;
    logic       Abierto;
    logic       Alarma;
    logic       Bloqueo;
    logic       GrantEnt;
    logic       GrantSal;
    logic [1:0] Intentos;

    modport master (
        output VehiculoEnt, VehiculoSal, enterPin, Pin, TerminoEnt, TerminoSal,
        input  Cerrado, Abierto, Alarma, Bloqueo, GrantEnt, GrantSal, Intentos
    );

    modport slave (
        input  VehiculoEnt, VehiculoSal, enterPin, Pin, TerminoEnt, TerminoSal,
        output Cerrado, Abierto, Alarma, Bloqueo, GrantEnt, GrantSal, Intentos
    );

endinterface

// File: rtl/arbitro_compuerta_verificador_pin.sv
// Keypad strobe edge detector, PIN comparator and saturating wrong-PIN counter.
// pin_ok/pin_mal pulse once per strobe rising edge, only while habilitado is high.
module arbitro_compuerta_verificador_pin
    import arbitro_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter int         MAX_INTENTOS = MAX_INTENTOS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_pin,
    input  logic [7:0] pin,
    input  logic       habilitado,
    input  logic       limpiar,
    output logic       pin_ok,
    output logic       pin_mal,
    output logic [1:0] intentos
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_INTENTOS);

    logic enter_q;
    logic pin_ev;

    assign pin_ev  = enter_pin & ~enter_q;
    assign pin_ok  = habilitado & pin_ev & (pin == PIN_CORRECTO);
    assign pin_mal = habilitado & pin_ev & (pin != PIN_CORRECTO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q  <= 1'b0;
            intentos <= '0;
        end else begin
            enter_q <= enter_pin;
            if (limpiar) begin
                intentos <= '0;
            end else if (pin_mal && (intentos != MAX_CNT)) begin
                intentos <= intentos + 2'd1;
            end
        end
    end

endmodule

// File: rtl/arbitro_compuerta.sv
// Shares one barrier between a PIN-protected entry lane and a free exit lane:
// round-robin grant, PIN sequencing, wrong-PIN alarm and tailgating lockout.
module arbitro_compuerta
    import arbitro_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter int         MAX_INTENTOS = MAX_INTENTOS_DEF,
    parameter int         T_ESPERA     = T_ESPERA_DEF
) (
    input logic               Clk,
    input logic               Reset,
    arbitro_compuerta_if.slave bus
);

    localparam int         ESP_W  = $clog2(T_ESPERA + 1);
    localparam logic [1:0] UMBRAL = 2'(MAX_INTENTOS - 1);

    estado_t          estado;
    carril_t          ultimo;
    salidas_t         sal_q;
    logic [ESP_W-1:0] espera;

    logic       habilitado;
    logic       pin_ok;
    logic       pin_mal;
    logic [1:0] intentos;

    assign habilitado = (estado == VERIF_PIN) || (estado == ALARMA) || (estado == BLOQUEO);

    // Any accepted correct PIN breaks the run of consecutive failures.
    arbitro_compuerta_verificador_pin #(
        .PIN_CORRECTO (PIN_CORRECTO),
        .MAX_INTENTOS (MAX_INTENTOS)
    ) u_verificador (
        .clk        (Clk),
        .rst        (Reset),
        .enter_pin  (bus.enterPin),
        .pin        (bus.Pin),
        .habilitado (habilitado),
        .limpiar    (pin_ok),
        .pin_mal    (pin_mal),
        .pin_ok     (pin_ok),
        .intentos   (intentos)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            estado <= IDLE;
            sal_q  <= salidas_de(IDLE);
            ultimo <= SAL;
            espera <= '0;
        end else begin
            espera <= '0;
            case (estado)
                IDLE: begin
                    if (bus.VehiculoEnt && (!bus.VehiculoSal || ultimo == SAL)) begin
                        estado <= VERIF_PIN;
                        sal_q  <= salidas_de(VERIF_PIN);
                        ultimo <= ENT;
                    end else if (bus.VehiculoSal) begin
                        estado <= ABIERTO_SAL;
                        sal_q  <= salidas_de(ABIERTO_SAL);
                        ultimo <= SAL;
                    end
                end
                VERIF_PIN: begin
                    if (pin_ok) begin
                        estado <= ABIERTO_ENT;
                        sal_q  <= salidas_de(ABIERTO_ENT);
                    end else if (pin_mal && (intentos >= UMBRAL)) begin
                        estado <= ALARMA;
                        sal_q  <= salidas_de(ALARMA);
                    end else if (!bus.VehiculoEnt) begin
                        estado <= IDLE;
                        sal_q  <= salidas_de(IDLE);
                    end else if (bus.VehiculoSal && !pin_mal) begin
                        // Entry has stalled too long with exit waiting: yield to exit.
                        if (espera == ESP_W'(T_ESPERA - 1)) begin
                            estado <= IDLE;
                            sal_q  <= salidas_de(IDLE);
                            ultimo <= ENT;
                        end else begin
                            espera <= espera + 1'b1;
                        end
                    end
                end
                ALARMA: begin
                    if (pin_ok) begin
                        estado <= ABIERTO_ENT;
                        sal_q  <= salidas_de(ABIERTO_ENT);
                    end
                end
                ABIERTO_ENT: begin
                    if (bus.TerminoEnt) begin
                        estado <= bus.VehiculoEnt ? BLOQUEO : IDLE;
                        sal_q  <= salidas_de(bus.VehiculoEnt ? BLOQUEO : IDLE);
                    end
                end
                ABIERTO_SAL: begin
                    if (bus.TerminoSal) begin
                        estado <= IDLE;
                        sal_q  <= salidas_de(IDLE);
                    end
                end
                BLOQUEO: begin
                    if (pin_ok) begin
                        estado <= IDLE;
                        sal_q  <= salidas_de(IDLE);
                    end
                end
                default: begin
                    estado <= IDLE;
                    sal_q  <= salidas_de(IDLE);
                end
            endcase
        end
    end

    assign bus.Cerrado  = sal_q.cerrado;
    assign bus.Abierto  = sal_q.abierto;
    assign bus.Alarma   = sal_q.alarma;
    assign bus.Bloqueo  = sal_q.bloqueo;
    assign bus.GrantEnt = sal_q.grant_ent;
    assign bus.GrantSal = sal_q.grant_sal;
    assign bus.Intentos = intentos;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Bench for arbitro_compuerta: directed vector table, hand sequences for round-robin,
// wait timeout and async reset, then random traffic against a behavioural model.
module tb_arbitro_compuerta;

    localparam logic [7:0] PIN_OK_TB = 8'h08;
    localparam int         MAX_TB    = 3;
    localparam int         ESPERA_TB = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    arbitro_compuerta_if ifc ();

    arbitro_compuerta dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         ve;
        bit         vs;
        bit         ep;
        logic [7:0] pin;
        bit         te;
        bit         ts;
        logic [7:0] exp;
    } vec_t;

    vec_t tabla[$];

    // Behavioural model: who owns the barrier, whether it is open, alarm/lock flags.
    bit m_owner_ent, m_owner_sal, m_open, m_alarm, m_lock, m_last_ent, m_prev_strobe;
    int m_intentos, m_wait;

    function automatic logic [7:0] pk(bit c, bit a, bit al, bit bl, bit ge, bit gs, logic [1:0] i);
        return {c, a, al, bl, ge, gs, i};
    endfunction

    function automatic vec_t mk(bit ve, bit vs, bit ep, logic [7:0] pin, bit te, bit ts, logic [7:0] exp);
        vec_t v;
        v.ve = ve; v.vs = vs; v.ep = ep; v.pin = pin; v.te = te; v.ts = ts; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input bit ve, input bit vs, input bit ep, input logic [7:0] pin,
                                 input bit te, input bit ts);
        ifc.VehiculoEnt = ve;
        ifc.VehiculoSal = vs;
        ifc.enterPin    = ep;
        ifc.Pin         = pin;
        ifc.TerminoEnt  = te;
        ifc.TerminoSal  = ts;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {ifc.Cerrado, ifc.Abierto, ifc.Alarma, ifc.Bloqueo, ifc.GrantEnt, ifc.GrantSal, ifc.Intentos};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, required %b (C A Al Bl GE GS I1 I0) at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic modelReset();
        m_owner_ent = 0; m_owner_sal = 0; m_open = 0; m_alarm = 0; m_lock = 0;
        m_last_ent = 0; m_prev_strobe = 0; m_intentos = 0; m_wait = 0;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        Reset = 1'b1;
        #2;
        checkOutput("reset_state", pk(1, 0, 0, 0, 0, 0, 2'd0));
        Reset = 1'b0;
        modelReset();
    endtask

    task automatic modelStep();
        bit strobe, good, bad;
        strobe = ifc.enterPin && !m_prev_strobe;
        m_prev_strobe = ifc.enterPin;
        good = strobe && (ifc.Pin == PIN_OK_TB);
        bad  = strobe && (ifc.Pin != PIN_OK_TB);
        if (m_lock) begin
            if (good) begin
                m_lock = 0; m_intentos = 0;
            end else if (bad && m_intentos < MAX_TB) begin
                m_intentos++;
            end
        end else if (m_alarm) begin
            if (good) begin
                m_alarm = 0; m_open = 1; m_intentos = 0;
            end
        end else if (m_open) begin
            if (m_owner_ent && ifc.TerminoEnt) begin
                m_open = 0; m_owner_ent = 0;
                if (ifc.VehiculoEnt) m_lock = 1;
            end else if (m_owner_sal && ifc.TerminoSal) begin
                m_open = 0; m_owner_sal = 0;
            end
        end else if (m_owner_ent) begin
            if (good) begin
                m_open = 1; m_intentos = 0; m_wait = 0;
            end else if (bad) begin
                m_wait = 0;
                if (m_intentos < MAX_TB) m_intentos++;
                if (m_intentos == MAX_TB) m_alarm = 1;
                else if (!ifc.VehiculoEnt) m_owner_ent = 0;
            end else if (!ifc.VehiculoEnt) begin
                m_owner_ent = 0; m_wait = 0;
            end else if (ifc.VehiculoSal) begin
                m_wait++;
                if (m_wait == ESPERA_TB) begin
                    m_owner_ent = 0; m_wait = 0; m_last_ent = 1;
                end
            end else begin
                m_wait = 0;
            end
        end else begin
            if (ifc.VehiculoEnt && (!ifc.VehiculoSal || !m_last_ent)) begin
                m_owner_ent = 1; m_last_ent = 1;
            end else if (ifc.VehiculoSal) begin
                m_owner_sal = 1; m_open = 1; m_last_ent = 0;
            end
        end
    endtask

    function automatic logic [7:0] modelExp();
        return pk(!m_open, m_open, m_alarm, m_lock, m_owner_ent, m_owner_sal, 2'(m_intentos));
    endfunction

    initial begin
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0, 0);

        // Directed table: correct PIN, wrong PINs to alarm, tailgating lockout, PIN ignored in IDLE.
        tabla.push_back(mk(1, 0, 0, 8'h00, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 1, 8'h08, 0, 0, pk(0, 1, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 0, 8'h08, 0, 0, pk(0, 1, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(0, 0, 0, 8'h08, 1, 0, pk(1, 0, 0, 0, 0, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 0, 8'h00, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 1, 8'hFF, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd1)));
        tabla.push_back(mk(1, 0, 0, 8'hFF, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd1)));
        tabla.push_back(mk(1, 0, 1, 8'hFF, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd2)));
        tabla.push_back(mk(1, 0, 0, 8'hFF, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd2)));
        tabla.push_back(mk(1, 0, 1, 8'hFF, 0, 0, pk(1, 0, 1, 0, 1, 0, 2'd3)));
        tabla.push_back(mk(1, 0, 0, 8'h00, 0, 0, pk(1, 0, 1, 0, 1, 0, 2'd3)));
        tabla.push_back(mk(1, 0, 0, 8'h08, 0, 0, pk(1, 0, 1, 0, 1, 0, 2'd3)));
        tabla.push_back(mk(1, 0, 1, 8'h08, 0, 0, pk(0, 1, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 1, 8'hFF, 0, 0, pk(0, 1, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(0, 0, 0, 8'h00, 1, 0, pk(1, 0, 0, 0, 0, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 0, 8'h00, 0, 0, pk(1, 0, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 1, 8'h08, 0, 0, pk(0, 1, 0, 0, 1, 0, 2'd0)));
        tabla.push_back(mk(1, 0, 0, 8'h08, 1, 0, pk(1, 0, 0, 1, 0, 0, 2'd0)));
        tabla.push_back(mk(0, 0, 1, 8'hFF, 0, 0, pk(1, 0, 0, 1, 0, 0, 2'd1)));
        tabla.push_back(mk(0, 0, 0, 8'hFF, 0, 0, pk(1, 0, 0, 1, 0, 0, 2'd1)));
        tabla.push_back(mk(0, 0, 1, 8'h08, 0, 0, pk(1, 0, 0, 0, 0, 0, 2'd0)));
        tabla.push_back(mk(0, 0, 0, 8'hFF, 0, 0, pk(1, 0, 0, 0, 0, 0, 2'd0)));
        tabla.push_back(mk(0, 0, 1, 8'hFF, 0, 0, pk(1, 0, 0, 0, 0, 0, 2'd0)));

        #1;
        doReset();
        foreach (tabla[i]) begin
            applyStimulus(tabla[i].ve, tabla[i].vs, tabla[i].ep, tabla[i].pin, tabla[i].te, tabla[i].ts);
            tick();
            checkOutput($sformatf("table_vec%0d", i), tabla[i].exp);
        end

        // Round-robin: simultaneous requests after reset go to entry, then exit, then entry.
        doReset();
        applyStimulus(1, 1, 0, 8'h00, 0, 0); tick();
        checkOutput("rr_first_ent", pk(1, 0, 0, 0, 1, 0, 2'd0));
        applyStimulus(1, 1, 1, 8'h08, 0, 0); tick();
        checkOutput("rr_ent_open", pk(0, 1, 0, 0, 1, 0, 2'd0));
        applyStimulus(0, 1, 0, 8'h08, 1, 0); tick();
        checkOutput("rr_ent_done", pk(1, 0, 0, 0, 0, 0, 2'd0));
        applyStimulus(1, 1, 0, 8'h08, 0, 0); tick();
        checkOutput("rr_sal_open", pk(0, 1, 0, 0, 0, 1, 2'd0));
        applyStimulus(1, 1, 0, 8'h08, 1, 1); tick();
        checkOutput("rr_sal_done", pk(1, 0, 0, 0, 0, 0, 2'd0));
        applyStimulus(1, 1, 0, 8'h08, 0, 0); tick();
        checkOutput("rr_ent_again", pk(1, 0, 0, 0, 1, 0, 2'd0));

        // Entry stalls in PIN verification while exit waits: yields after exactly 16 cycles.
        doReset();
        applyStimulus(1, 1, 0, 8'h00, 0, 0); tick();
        checkOutput("timeout_grant", pk(1, 0, 0, 0, 1, 0, 2'd0));
        for (int k = 1; k < ESPERA_TB; k++) begin
            tick();
            checkOutput($sformatf("timeout_hold%0d", k), pk(1, 0, 0, 0, 1, 0, 2'd0));
        end
        tick();
        checkOutput("timeout_release", pk(1, 0, 0, 0, 0, 0, 2'd0));
        tick();
        checkOutput("timeout_sal_open", pk(0, 1, 0, 0, 0, 1, 2'd0));

        // Asynchronous reset while the barrier is open closes it before the next edge.
        doReset();
        applyStimulus(0, 1, 0, 8'h00, 0, 0); tick();
        checkOutput("async_open", pk(0, 1, 0, 0, 0, 1, 2'd0));
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_reset_closed", pk(1, 0, 0, 0, 0, 0, 2'd0));
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        #1;
        Reset = 1'b0;
        tick();
        checkOutput("async_after", pk(1, 0, 0, 0, 0, 0, 2'd0));

        // Random traffic against the behavioural model.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            int r;
            if ($urandom_range(0, 299) == 0) begin
                doReset();
                continue;
            end
            if ($urandom_range(0, 9) < 2) ifc.VehiculoEnt = ~ifc.VehiculoEnt;
            if ($urandom_range(0, 9) < 2) ifc.VehiculoSal = ~ifc.VehiculoSal;
            if ($urandom_range(0, 9) < 4) ifc.enterPin = ~ifc.enterPin;
            r = $urandom_range(0, 9);
            ifc.Pin = (r < 5) ? PIN_OK_TB : (r < 9) ? 8'hFF : 8'($urandom());
            ifc.TerminoEnt = ($urandom_range(0, 6) == 0);
            ifc.TerminoSal = ($urandom_range(0, 6) == 0);
            @(posedge Clk);
            modelStep();
            #1;
            checkOutput($sformatf("random_cycle%0d", n), modelExp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
